// File: rtl/reader_sequencer.sv
// Paces a non-stallable character reader into a valid/ready stream.
// The reader is stopped when the FIFO fills; on restart the stream is replayed and already-delivered characters are skipped.
module reader_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int HIGH_WATER = 6,
    parameter int LOW_WATER  = 2,
    parameter int MAX_CHARS  = 255,
    parameter int CHAR_BITES = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            page,
    output logic                  rd_state_enable,
    output logic [7:0]            rd_argument,
    input  logic                  rd_has_finished,
    input  logic [CHAR_BITES-1:0] rd_char,
    output logic [CHAR_BITES-1:0] out_char,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] HW    = CW'(HIGH_WATER);
    localparam logic [CW-1:0] LW    = CW'(LOW_WATER);
    localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);
    localparam logic [7:0]    MAX_C = 8'(MAX_CHARS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic                  en_q;
    logic                  en_dly_q;
    logic [7:0]            arg_q, arg_d;
    logic [7:0]            delivered_q, delivered_d;
    logic [7:0]            seen_q, seen_d;
    logic                  term_q, term_d;
    logic                  ovf_q, ovf_d;
    logic [CW-1:0]         count_q, count_d;
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CHAR_BITES-1:0] mem_q [FIFO_DEPTH];

    logic sample_vld, replay, is_nul, capped, push, pop, nul_now, hit_max, done_c;

    always_comb begin
        state_d     = state_q;
        arg_d       = arg_q;
        delivered_d = delivered_q;
        seen_d      = seen_q;
        term_d      = term_q;
        ovf_d       = ovf_q;
        push        = 1'b0;
        nul_now     = 1'b0;
        done_c      = 1'b0;

        // en_dly_q covers the one sample still in flight after enable drops
        sample_vld = en_dly_q && !rd_has_finished && (state_q != S_IDLE);
        replay     = seen_q < delivered_q;
        is_nul     = (rd_char == '0);
        capped     = (delivered_q == MAX_C);
        pop        = (count_q != '0) && out_ready;

        if (sample_vld) begin
            if (seen_q != 8'hFF) seen_d = seen_q + 8'd1;
            if (!replay && !term_q) begin
                if (is_nul) begin
                    nul_now = 1'b1;
                    term_d  = 1'b1;
                end else if (!capped && (count_q != FULL || pop)) begin
                    push = 1'b1;
                end
            end
        end

        if (push) delivered_d = delivered_q + 8'd1;
        count_d = count_q + CW'(push) - CW'(pop);
        hit_max = push && (delivered_d == MAX_C);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    arg_d       = page;
                    delivered_d = '0;
                    seen_d      = '0;
                    term_d      = 1'b0;
                    ovf_d       = 1'b0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (term_d || rd_has_finished || hit_max) begin
                    state_d = S_FINISH;
                    if (hit_max) ovf_d = 1'b1;
                end else if (count_d >= HW) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (nul_now) begin
                    state_d = S_FINISH;
                end else if (hit_max) begin
                    state_d = S_FINISH;
                    ovf_d   = 1'b1;
                end else if (count_q <= LW && !en_dly_q) begin
                    // reader has been held off a full cycle, so it restarts at char 0
                    seen_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_FINISH: begin
                if (count_q == '0 && !en_dly_q) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            en_q        <= 1'b0;
            en_dly_q    <= 1'b0;
            arg_q       <= '0;
            delivered_q <= '0;
            seen_q      <= '0;
            term_q      <= 1'b0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            en_q        <= (state_d == S_RUN);
            en_dly_q    <= en_q;
            arg_q       <= arg_d;
            delivered_q <= delivered_d;
            seen_q      <= seen_d;
            term_q      <= term_d;
            ovf_q       <= ovf_d;
            count_q     <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= rd_char;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign rd_state_enable = en_q;
    assign rd_argument     = arg_q;
    assign out_char        = mem_q[rd_ptr_q];
    assign out_valid       = (count_q != '0);
    assign busy            = (state_q != S_IDLE);
    assign done            = done_c;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_reader_sequencer.sv
// Bench for reader_sequencer: two instances (default and MAX_CHARS=10) fed by behavioural rewinding readers.
module tb_reader_sequencer;

    logic       clk, rst, start, out_ready;
    logic [7:0] page;
    logic       en0, en1, fin0, fin1, ov0, ov1, busy0, busy1, done0, done1, ovf0, ovf1;
    logic [7:0] arg0, arg1, ch0, ch1, oc0, oc1;
    int         ridx0, ridx1;

    reader_sequencer dut0 (
        .clock(clk), .reset(rst), .start(start), .page(page),
        .rd_state_enable(en0), .rd_argument(arg0), .rd_has_finished(fin0), .rd_char(ch0),
        .out_char(oc0), .out_valid(ov0), .out_ready(out_ready),
        .busy(busy0), .done(done0), .overflow(ovf0)
    );

    reader_sequencer #(.MAX_CHARS(10)) dut1 (
        .clock(clk), .reset(rst), .start(start), .page(page),
        .rd_state_enable(en1), .rd_argument(arg1), .rd_has_finished(fin1), .rd_char(ch1),
        .out_char(oc1), .out_valid(ov1), .out_ready(out_ready),
        .busy(busy1), .done(done1), .overflow(ovf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- page content seen by the readers ----------------
    string      DUMMY = "<html><body><p>Hello, tiny world!!</p></body></html>";
    string      SHORT = "<p>";
    logic [7:0] rnd_mem [64];
    int         rnd_len;

    function automatic int page_len(input logic [7:0] pg);
        case (pg)
            8'd1:    return 53;       // 52 chars plus NUL
            8'd2:    return 3;        // no terminator, ends by has_finished
            8'd3:    return rnd_len;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] page_byte(input logic [7:0] pg, input int i);
        logic [7:0] b;
        b = 8'h00;
        case (pg)
            8'd1: if (i < 52) b = DUMMY[i];
            8'd2: b = SHORT[i];
            8'd3: b = rnd_mem[i];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Reader: emits one char per enabled cycle, rewinds whenever enable is low
    always @(posedge clk) begin
        if (rst || !en0) begin
            ridx0 <= 0; ch0 <= 8'h00; fin0 <= 1'b0;
        end else if (ridx0 < page_len(arg0)) begin
            ch0 <= page_byte(arg0, ridx0); ridx0 <= ridx0 + 1; fin0 <= 1'b0;
        end else begin
            fin0 <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rst || !en1) begin
            ridx1 <= 0; ch1 <= 8'h00; fin1 <= 1'b0;
        end else if (ridx1 < page_len(arg1)) begin
            ch1 <= page_byte(arg1, ridx1); ridx1 <= ridx1 + 1; fin1 <= 1'b0;
        end else begin
            fin1 <= 1'b1;
        end
    end

    // ---------------- checking infrastructure ----------------
    int checks, errors;
    int ready_mode, cyc;
    logic [7:0] got0[$], got1[$], exp0[$], exp1[$];
    int done_cnt0, done_cnt1, done_sz0, done_sz1, en_rise0, peak0;
    logic en0_prev;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic ready_now();
        case (ready_mode)
            0:       return 1'b1;
            1:       return cyc >= 20;
            2:       return (cyc % 3) == 0;
            3:       return $urandom_range(0, 3) != 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic monitor();
        if (ov0 && out_ready) got0.push_back(oc0);
        if (ov1 && out_ready) got1.push_back(oc1);
        if (done0) begin done_cnt0++; done_sz0 = got0.size(); end
        if (done1) begin done_cnt1++; done_sz1 = got1.size(); end
        if (en0 && !en0_prev) en_rise0++;
        en0_prev = en0;
        if (int'(dut0.count_q) > peak0) peak0 = int'(dut0.count_q);
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        out_ready = ready_now();
    endtask

    task automatic clear_mon();
        got0.delete(); got1.delete();
        done_cnt0 = 0; done_cnt1 = 0; done_sz0 = -1; done_sz1 = -1;
        en_rise0 = 0; peak0 = 0; en0_prev = en0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!(done_cnt0 > 0 && done_cnt1 > 0) && n < budget) begin
            step();
            n++;
        end
        chk("done_within_budget", (n < budget) ? 1 : 0, 1);
        repeat (8) step();
    endtask

    task automatic run_xfer(input logic [7:0] pg, input int mode);
        clear_mon();
        ready_mode = mode;
        cyc        = 0;
        out_ready  = ready_now();
        page       = pg;
        start      = 1'b1;
        step();
        start      = 1'b0;
        wait_done(5000);
    endtask

    // Reference: page text up to the first NUL, truncated to MAX_CHARS
    task automatic check_xfer(input logic [7:0] pg);
        int d0, d1;
        exp0.delete(); exp1.delete();
        for (int i = 0; i < page_len(pg); i++) begin
            if (page_byte(pg, i) == 8'h00) break;
            exp0.push_back(page_byte(pg, i));
        end
        for (int i = 0; i < exp0.size() && i < 10; i++) exp1.push_back(exp0[i]);
        chk("len_max255", got0.size(), exp0.size());
        chk("len_max10", got1.size(), exp1.size());
        d0 = -1;
        for (int i = 0; i < got0.size() && i < exp0.size(); i++)
            if (got0[i] !== exp0[i]) begin d0 = i; break; end
        d1 = -1;
        for (int i = 0; i < got1.size() && i < exp1.size(); i++)
            if (got1[i] !== exp1[i]) begin d1 = i; break; end
        chk("first_bad_char_idx_max255", d0, -1);
        chk("first_bad_char_idx_max10", d1, -1);
        chk("done_count_max255", done_cnt0, 1);
        chk("done_count_max10", done_cnt1, 1);
        chk("done_after_last_pop_max255", done_sz0, exp0.size());
        chk("done_after_last_pop_max10", done_sz1, exp1.size());
        chk("overflow_max255", int'(ovf0), (exp0.size() >= 255) ? 1 : 0);
        chk("overflow_max10", int'(ovf1), (exp0.size() >= 10) ? 1 : 0);
    endtask

    typedef struct {
        logic [7:0] pg;
        int         mode;
        int         len0;
        int         ovf0;
        int         len1;
        int         ovf1;
        int         min_restarts;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int n;
        checks = 0; errors = 0;
        tbl[0] = '{8'd2, 0,  3, 0,  3, 0, 0};
        tbl[1] = '{8'd1, 0, 52, 0, 10, 1, 0};
        tbl[2] = '{8'd1, 1, 52, 0, 10, 1, 1};
        tbl[3] = '{8'd1, 2, 52, 0, 10, 1, 2};

        rst = 1'b1; start = 1'b0; page = 8'h00; out_ready = 1'b0; ready_mode = 4; cyc = 0;
        rnd_len = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enable", int'(en0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_overflow", int'(ovf0), 0);
        chk("rst_out_valid", int'(ov0), 0);
        chk("rst_argument", int'(arg0), 0);
        chk("rst_out_char", int'(oc0), 0);
        rst = 1'b0;
        repeat (2) step();

        for (int v = 0; v < 4; v++) begin
            run_xfer(tbl[v].pg, tbl[v].mode);
            chk("tbl_len_max255", got0.size(), tbl[v].len0);
            chk("tbl_ovf_max255", int'(ovf0), tbl[v].ovf0);
            chk("tbl_len_max10", got1.size(), tbl[v].len1);
            chk("tbl_ovf_max10", int'(ovf1), tbl[v].ovf1);
            chk("tbl_restarts", (en_rise0 - 1 >= tbl[v].min_restarts) ? 1 : 0, 1);
            if (tbl[v].mode == 1) begin
                chk("peak_reaches_high_water", (peak0 >= 6) ? 1 : 0, 1);
                chk("peak_within_depth", (peak0 <= 8) ? 1 : 0, 1);
            end
            check_xfer(tbl[v].pg);
        end

        // start-to-output latency, and overflow cleared by the next start
        chk("overflow_sticky_before_start", int'(ovf1), 1);
        clear_mon();
        ready_mode = 0; cyc = 0; out_ready = 1'b1;
        page = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_busy", int'(busy0), 1);
        chk("t1_enable", int'(en0), 1);
        chk("t1_argument", int'(arg0), 1);
        chk("t1_overflow_cleared", int'(ovf1), 0);
        chk("t1_out_valid", int'(ov0), 0);
        step();
        chk("t2_out_valid", int'(ov0), 0);
        step();
        chk("t3_out_valid", int'(ov0), 1);
        chk("t3_out_char", int'(oc0), 8'h3C);
        wait_done(5000);
        check_xfer(8'd1);

        // reset while paused: abort with no done, then a clean transfer
        clear_mon();
        ready_mode = 4; cyc = 0; out_ready = 1'b0;
        page = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(en_rise0 > 0 && busy0 && !en0) && n < 200) begin
            step();
            n++;
        end
        chk("pause_reached", (n < 200) ? 1 : 0, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_pause_enable", int'(en0), 0);
        chk("rst_pause_out_valid", int'(ov0), 0);
        chk("rst_pause_busy", int'(busy0), 0);
        repeat (6) step();
        chk("rst_pause_no_done", done_cnt0, 0);
        run_xfer(8'd1, 0);
        chk("after_rst_len", got0.size(), 52);
        check_xfer(8'd1);

        // random pages, random backpressure
        for (int k = 0; k < 8; k++) begin
            rnd_len = $urandom_range(0, 60);
            for (int i = 0; i < 64; i++) rnd_mem[i] = 8'($urandom_range(1, 255));
            if (rnd_len > 0 && $urandom_range(0, 1) == 1)
                rnd_mem[$urandom_range(0, rnd_len - 1)] = 8'h00;
            run_xfer(8'd3, 3);
            check_xfer(8'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
